// File: rtl/memctrl_arbiter.sv
// memctrl_arbiter
//   Round-robin front end that shares one single-port memory among NUM_REQ
//   requesters. One request is accepted at a time over valid/ready. The access
//   is sequenced as IDLE -> ACCESS -> (WAIT x RD_LAT for reads) -> IDLE.
//   Read data is returned to the originating requester with a one-cycle strobe.
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid/req_rw          per-requester request and op (1=write)
//   req_addr/req_wdata        packed per-requester address / write data
//   req_ready                 one-hot accept (combinational, IDLE only)
//   rsp_valid/rsp_rdata       one-hot read strobe and read data
//   busy                      high whenever the controller is not IDLE
//   mem_rw/mem_addr/mem_datain/mem_dataout   memory side
module memctrl_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        busy,
  output logic                        mem_rw,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_datain,
  input  logic [DATA_W-1:0]           mem_dataout
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t                 state_r;
  logic [ID_W-1:0]        rr_ptr_r;
  logic [ID_W-1:0]        id_r;
  logic                   rw_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [NUM_REQ-1:0]     rsp_valid_r;
  logic [DATA_W-1:0]      rsp_rdata_r;
  logic                   mem_rw_r;
  logic [ADDR_W-1:0]      mem_addr_r;
  logic [DATA_W-1:0]      mem_datain_r;

  logic [ID_W-1:0]        win_id_s;
  logic                   win_found_s;
  logic [NUM_REQ-1:0]     grant_s;
  logic [NUM_REQ-1:0]     ready_s;
  logic                   hs_s;
  logic [ID_W-1:0]        next_ptr_s;
  logic                   sel_rw_s;
  logic [ADDR_W-1:0]      sel_addr_s;
  logic [DATA_W-1:0]      sel_wdata_s;

  // One-hot strobe for a requester id.
  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Round-robin search starting at rr_ptr; the first valid requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    win_id_s    = '0;
    win_found_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_r) + k) % NUM_REQ;
      if (!win_found_s && req_valid[idx]) begin
        win_found_s = 1'b1;
        win_id_s    = ID_W'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
    grant_s = '0;
    if (win_found_s) begin
      grant_s[win_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Accept only in IDLE; held low while reset is asserted.
  always_comb begin
    if ((state_r == IDLE) && reset_n) begin
      ready_s = grant_s;
    end else begin
      ready_s = '0;
    end
    hs_s = |(req_valid & ready_s);
  end

  // Winner's request fields and the pointer value one past the winner.
  always_comb begin
    sel_rw_s    = req_rw[win_id_s];
    sel_addr_s  = req_addr[int'(win_id_s)*ADDR_W +: ADDR_W];
    sel_wdata_s = req_wdata[int'(win_id_s)*DATA_W +: DATA_W];
    if (win_id_s == ID_W'(NUM_REQ - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = win_id_s + ID_W'(1);
    end
  end

  // Access sequencer: grant latch, memory drive, read wait and response strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      rr_ptr_r     <= '0;
      id_r         <= '0;
      rw_r         <= 1'b0;
      cnt_r        <= '0;
      rsp_valid_r  <= '0;
      rsp_rdata_r  <= '0;
      mem_rw_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_datain_r <= '0;
    end else begin
      rsp_valid_r <= '0;
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            id_r         <= win_id_s;
            rw_r         <= sel_rw_s;
            mem_rw_r     <= sel_rw_s;
            mem_addr_r   <= sel_addr_s;
            mem_datain_r <= sel_wdata_s;
            rr_ptr_r     <= next_ptr_s;
            state_r      <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          mem_rw_r <= 1'b0;
          if (rw_r) begin
            state_r <= IDLE;
          end else begin
            cnt_r   <= CNT_W'(RD_LAT);
            state_r <= WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            rsp_rdata_r <= mem_dataout;
            rsp_valid_r <= id_onehot(id_r);
            state_r     <= IDLE;
          end else begin
            state_r <= WAIT;
          end
        end
        default: begin
          mem_rw_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_rdata  = rsp_rdata_r;
  assign busy       = (state_r != IDLE);
  assign mem_rw     = mem_rw_r;
  assign mem_addr   = mem_addr_r;
  assign mem_datain = mem_datain_r;

endmodule

// File: tb/tb_memctrl_arbiter.sv
// tb_memctrl_arbiter
//   Two instances: dut_a (RD_LAT=1) carries most scenarios, dut_b (RD_LAT=3)
//   covers the longer read latency. Each has a small behavioural memory.
//   Expected grants, writes and responses are queued by the stimulus and
//   popped by negedge monitors.
module tb_memctrl_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } rsp_t;

  logic        clk;
  logic        reset_n;

  logic [1:0]  req_valid_a, req_rw_a, req_ready_a, rsp_valid_a;
  logic [15:0] req_addr_a, req_wdata_a;
  logic [7:0]  rsp_rdata_a, mem_addr_a, mem_datain_a, mem_dataout_a;
  logic        busy_a, mem_rw_a;

  logic [1:0]  req_valid_b, req_rw_b, req_ready_b, rsp_valid_b;
  logic [15:0] req_addr_b, req_wdata_b;
  logic [7:0]  rsp_rdata_b, mem_addr_b, mem_datain_b, mem_dataout_b;
  logic        busy_b, mem_rw_b;

  logic [7:0]  mem_a [256];
  logic [7:0]  pipe_a;
  logic [7:0]  mem_b [256];
  logic [7:0]  pipe_b [3];

  int   checks;
  int   errors;
  int   rsp_cnt_a;
  int   exp_gnt_q [$];
  logic [15:0] exp_wr_q [$];
  rsp_t exp_rsp_q [$];
  rsp_t exp_rsp_b_q [$];

  memctrl_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_a), .req_rw(req_rw_a), .req_addr(req_addr_a),
    .req_wdata(req_wdata_a), .req_ready(req_ready_a), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rsp_rdata_a), .busy(busy_a), .mem_rw(mem_rw_a),
    .mem_addr(mem_addr_a), .mem_datain(mem_datain_a), .mem_dataout(mem_dataout_a)
  );

  memctrl_arbiter #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_b), .req_rw(req_rw_b), .req_addr(req_addr_b),
    .req_wdata(req_wdata_b), .req_ready(req_ready_b), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .busy(busy_b), .mem_rw(mem_rw_b),
    .mem_addr(mem_addr_b), .mem_datain(mem_datain_b), .mem_dataout(mem_dataout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: write on rw=1, read data appears RD_LAT cycles after sampling.
  always @(posedge clk) begin
    if (!reset_n) begin
      mem_a[8'h01] <= 8'h11;
      mem_a[8'h02] <= 8'h22;
      mem_b[8'h7F] <= 8'h3C;
    end else begin
      if (mem_rw_a) mem_a[mem_addr_a] <= mem_datain_a;
      if (mem_rw_b) mem_b[mem_addr_b] <= mem_datain_b;
    end
    pipe_a    <= mem_a[mem_addr_a];
    pipe_b[0] <= mem_b[mem_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_dataout_a = pipe_a;
  assign mem_dataout_b = pipe_b[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Grant monitor: each handshake must match the next expected requester.
  always @(negedge clk) begin
    logic [1:0] hs;
    int         id;
    hs = req_valid_a & req_ready_a;
    if (hs != 2'b00) begin
      if (exp_gnt_q.size() == 0) begin
        chk("grant_unexpected", 32'(hs), 32'(0));
      end else begin
        id = exp_gnt_q.pop_front();
        chk("grant", 32'(hs), 32'(1) << id);
      end
    end
  end

  // Write monitor: each memory write cycle must match the next expected write.
  always @(negedge clk) begin
    logic [15:0] w;
    if (mem_rw_a) begin
      if (exp_wr_q.size() == 0) begin
        chk("write_unexpected", 32'({mem_addr_a, mem_datain_a}), 32'hFFFF_FFFF);
      end else begin
        w = exp_wr_q.pop_front();
        chk("write", 32'({mem_addr_a, mem_datain_a}), 32'(w));
      end
    end
  end

  // Response monitors for both instances.
  always @(negedge clk) begin
    rsp_t e;
    if (rsp_valid_a != 2'b00) begin
      rsp_cnt_a++;
      if (exp_rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'({rsp_valid_a, rsp_rdata_a}), 32'hFFFF_FFFF);
      end else begin
        e = exp_rsp_q.pop_front();
        chk("rsp", 32'({rsp_valid_a, rsp_rdata_a}), 32'(e));
      end
    end
    if (rsp_valid_b != 2'b00) begin
      if (exp_rsp_b_q.size() == 0) begin
        chk("rsp_b_unexpected", 32'({rsp_valid_b, rsp_rdata_b}), 32'hFFFF_FFFF);
      end else begin
        e = exp_rsp_b_q.pop_front();
        chk("rsp_b", 32'({rsp_valid_b, rsp_rdata_b}), 32'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for req_ready[id] on dut_a; returns after the handshake edge (+1).
  task automatic wait_grant(input int id, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready_a[id]) break;
      n++;
      if (n > 50) begin
        chk("grant_timeout", 32'(n), 32'(0));
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, hs, cyc, cnt0;
    checks = 0; errors = 0; rsp_cnt_a = 0;
    reset_n = 1'b0;
    req_valid_a = 2'b00; req_rw_a = 2'b00; req_addr_a = 16'h0000; req_wdata_a = 16'h0000;
    req_valid_b = 2'b00; req_rw_b = 2'b00; req_addr_b = 16'h0000; req_wdata_b = 16'h0000;
    #3;
    chk("reset_busy", 32'(busy_a), 32'(0));
    chk("reset_ready", 32'(req_ready_a), 32'(0));
    chk("reset_mem_rw", 32'(mem_rw_a), 32'(0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // Both requesters continuously reading 01/02: grants 0,1,0,1.
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    exp_gnt_q.push_back(0); exp_gnt_q.push_back(1);
    exp_rsp_q.push_back('{id: 2'b01, data: 8'h11});
    exp_rsp_q.push_back('{id: 2'b10, data: 8'h22});
    exp_rsp_q.push_back('{id: 2'b01, data: 8'h11});
    exp_rsp_q.push_back('{id: 2'b10, data: 8'h22});
    req_rw_a = 2'b00; req_addr_a = {8'h02, 8'h01}; req_valid_a = 2'b11;
    hs = 0; cyc = 0;
    while (hs < 4 && cyc < 100) begin
      @(negedge clk);
      if ((req_valid_a & req_ready_a) != 2'b00) hs++;
      cyc++;
      if (hs == 4) begin
        @(posedge clk);
        #1 req_valid_a = 2'b00;
      end
    end
    chk("alt_grant_count", 32'(hs), 32'(4));
    repeat (6) step();

    // Write A5 to 10 then read it back on requester 0.
    exp_gnt_q.push_back(0);
    exp_wr_q.push_back({8'h10, 8'hA5});
    req_rw_a = 2'b01; req_addr_a = {8'h00, 8'h10}; req_wdata_a = {8'h00, 8'hA5};
    req_valid_a = 2'b01;
    wait_grant(0, n);
    req_valid_a = 2'b00;
    chk("wr_mem_rw", 32'(mem_rw_a), 32'(1));
    chk("wr_mem_addr", 32'(mem_addr_a), 32'h10);
    chk("wr_mem_datain", 32'(mem_datain_a), 32'hA5);
    step();
    chk("wr_mem_rw_drop", 32'(mem_rw_a), 32'(0));
    exp_gnt_q.push_back(0);
    exp_rsp_q.push_back('{id: 2'b01, data: 8'hA5});
    req_rw_a = 2'b00; req_valid_a = 2'b01;
    wait_grant(0, n);
    req_valid_a = 2'b00;
    step();
    chk("rd_rsp_t2", 32'(rsp_valid_a), 32'(0));
    step();
    chk("rd_rsp_t3", 32'(rsp_valid_a), 32'(1));
    chk("rd_rdata_t3", 32'(rsp_rdata_a), 32'hA5);
    step();

    // Reset asserted while a read is in WAIT: outputs clear, no response.
    exp_gnt_q.push_back(0);
    req_rw_a = 2'b00; req_addr_a = {8'h00, 8'h10}; req_valid_a = 2'b01;
    wait_grant(0, n);
    req_valid_a = 2'b00;
    step();
    chk("abort_busy_before", 32'(busy_a), 32'(1));
    cnt0 = rsp_cnt_a;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_a), 32'(0));
    chk("abort_mem_rw", 32'(mem_rw_a), 32'(0));
    chk("abort_mem_addr", 32'(mem_addr_a), 32'(0));
    chk("abort_mem_datain", 32'(mem_datain_a), 32'(0));
    chk("abort_rsp_valid", 32'(rsp_valid_a), 32'(0));
    chk("abort_rsp_rdata", 32'(rsp_rdata_a), 32'(0));
    chk("abort_ready", 32'(req_ready_a), 32'(0));
    repeat (2) step();
    reset_n = 1'b1;
    repeat (6) step();
    chk("abort_no_rsp", 32'(rsp_cnt_a), 32'(cnt0));

    // Back-to-back writes from requester 1 to 00 and FF.
    exp_gnt_q.push_back(1); exp_gnt_q.push_back(1);
    exp_wr_q.push_back({8'h00, 8'h5A});
    exp_wr_q.push_back({8'hFF, 8'hC3});
    req_rw_a = 2'b10; req_addr_a = {8'h00, 8'h00}; req_wdata_a = {8'h5A, 8'h00};
    req_valid_a = 2'b10;
    wait_grant(1, n);
    req_addr_a = {8'hFF, 8'h00}; req_wdata_a = {8'hC3, 8'h00};
    chk("b2b_busy_1", 32'(busy_a), 32'(1));
    step();
    chk("b2b_busy_0", 32'(busy_a), 32'(0));
    chk("b2b_ready", 32'(req_ready_a), 32'(2));
    wait_grant(1, n);
    req_valid_a = 2'b00;
    chk("b2b_gap", 32'(n), 32'(0));
    step();
    chk("b2b_mem_00", 32'(mem_a[8'h00]), 32'h5A);
    chk("b2b_mem_ff", 32'(mem_a[8'hFF]), 32'hC3);
    step();

    // Requester 1 raises valid while 0 is serviced, drops it before IDLE.
    exp_gnt_q.push_back(0);
    exp_rsp_q.push_back('{id: 2'b01, data: 8'h11});
    req_rw_a = 2'b00; req_addr_a = {8'h00, 8'h01}; req_valid_a = 2'b01;
    wait_grant(0, n);
    req_rw_a = 2'b10; req_addr_a = {8'h33, 8'h01}; req_wdata_a = {8'h44, 8'h00};
    req_valid_a = 2'b10;
    #1;
    chk("skip_ready_access", 32'(req_ready_a), 32'(0));
    step();
    chk("skip_ready_wait", 32'(req_ready_a), 32'(0));
    req_valid_a = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("skip_idle_busy", 32'(busy_a), 32'(0));
    end

    // RD_LAT=3 instance: read 7F preloaded with 3C.
    exp_rsp_b_q.push_back('{id: 2'b01, data: 8'h3C});
    req_rw_b = 2'b00; req_addr_b = {8'h00, 8'h7F}; req_valid_b = 2'b01;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      if (req_ready_b[0]) break;
      cyc++;
    end
    chk("lat3_grant_timeout", 32'(cyc < 50), 32'(1));
    @(posedge clk);
    #1 req_valid_b = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("lat3_busy", 32'(busy_b), 32'(1));
      chk("lat3_no_rsp", 32'(rsp_valid_b), 32'(0));
      step();
    end
    chk("lat3_busy_end", 32'(busy_b), 32'(0));
    chk("lat3_rsp_valid", 32'(rsp_valid_b), 32'(1));
    chk("lat3_rdata", 32'(rsp_rdata_b), 32'h3C);

    repeat (6) step();
    chk("gnt_q_empty", 32'(exp_gnt_q.size()), 32'(0));
    chk("wr_q_empty", 32'(exp_wr_q.size()), 32'(0));
    chk("rsp_q_empty", 32'(exp_rsp_q.size()), 32'(0));
    chk("rsp_b_q_empty", 32'(exp_rsp_b_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
